// File: rtl/dlx_decode_stage.sv
// dlx_decode_stage: DLX instruction decode with a registered ID/EX output, load-use interlock and MULT hold
module dlx_decode_stage #(
    parameter int ALUOP_W   = 5,
    parameter int MUL_LAT   = 4,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               RegWr,
    output logic               RegDst,
    output logic               ExtOp,
    output logic               ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               Branch,
    output logic               MemWr,
    output logic               MemToReg,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    output logic [4:0]         dst_o,
    output logic [15:0]        imm_o
);
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] BUBBLE  = 2'd1;
    localparam logic [1:0] MULHOLD = 2'd2;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;
    localparam logic [5:0] FN_MULT = 6'h0E;

    typedef struct packed {
        logic               reg_wr;
        logic               reg_dst;
        logic               ext_op;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               branch;
        logic               mem_wr;
        logic               mem_to_reg;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         dst;
        logic [15:0]        imm;
    } idex_t;

    idex_t         dec, idex_d, idex_q;
    logic          valid_d, valid_q;
    logic [1:0]    fsm_d, fsm_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [5:0]    op;
    logic [4:0]    wr_dst;
    logic          uses_rs2, is_mult, hazard, load, take, bubble;

    assign op       = instr[31:26];
    assign uses_rs2 = op == OP_R || op == OP_SW;
    assign is_mult  = op == OP_R && instr[5:0] == FN_MULT;

    // Decode the presented instruction; r0 destinations are squashed to no write
    always_comb begin
        dec     = idex_t'(0);
        dec.rs1 = instr[25:21];
        dec.rs2 = instr[20:16];
        dec.imm = instr[15:0];
        case (op)
            OP_R:    begin dec.reg_wr = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = ALUOP_W'(instr[4:0]); end
            OP_ADDI: begin dec.reg_wr = 1'b1; dec.ext_op = 1'b1; dec.alu_src = 1'b1; end
            OP_LW:   begin dec.reg_wr = 1'b1; dec.ext_op = 1'b1; dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1; end
            OP_SW:   begin dec.mem_wr = 1'b1; dec.ext_op = 1'b1; dec.alu_src = 1'b1; end
            OP_BEQZ, OP_BNEZ: begin dec.branch = 1'b1; dec.ext_op = 1'b1; dec.alu_op = ALUOP_W'(2); end
            default: ;
        endcase
        wr_dst     = dec.reg_dst ? instr[15:11] : instr[20:16];
        dec.reg_wr = dec.reg_wr && wr_dst != 5'd0;
        dec.dst    = dec.reg_wr ? wr_dst : 5'd0;
    end

    // A load in ID/EX whose destination feeds the presented instruction blocks it
    assign hazard = HAZARD_EN && valid_q && idex_q.mem_to_reg && idex_q.dst != 5'd0 && in_valid &&
                    (idex_q.dst == instr[25:21] || (uses_rs2 && idex_q.dst == instr[20:16]));
    assign load     = !valid_q || out_ready;
    assign in_ready = rst_n && fsm_q == RUN && load && !hazard;
    assign take     = in_valid && in_ready;
    assign bubble   = fsm_q == RUN && load && hazard;

    // ID/EX next value: new decode, bubble, or empty when free; otherwise hold
    always_comb begin
        valid_d = load ? take || bubble : valid_q;
        idex_d  = !load ? idex_q : take ? dec : idex_t'(0);
    end

    // Sequencer: one BUBBLE cycle after a load-use stall, MUL_LAT-1 EX-paced cycles after MULT
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        if (bubble) fsm_d = BUBBLE;
        else if (take && is_mult && MUL_LAT > 1) begin
            fsm_d = MULHOLD;
            cnt_d = CW'(MUL_LAT - 1);
        end
        else if (fsm_q == BUBBLE) fsm_d = RUN;
        else if (fsm_q == MULHOLD && out_ready) begin
            cnt_d = cnt_q - CW'(1);
            fsm_d = cnt_q == CW'(1) ? RUN : MULHOLD;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idex_q  <= idex_t'(0);
            fsm_q   <= RUN;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idex_q  <= idex_d;
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign RegWr     = idex_q.reg_wr;
    assign RegDst    = idex_q.reg_dst;
    assign ExtOp     = idex_q.ext_op;
    assign ALUSrc    = idex_q.alu_src;
    assign ALUOp     = idex_q.alu_op;
    assign Branch    = idex_q.branch;
    assign MemWr     = idex_q.mem_wr;
    assign MemToReg  = idex_q.mem_to_reg;
    assign rs1_o     = idex_q.rs1;
    assign rs2_o     = idex_q.rs2;
    assign dst_o     = idex_q.dst;
    assign imm_o     = idex_q.imm;
endmodule

// File: tb/tb_dlx_decode_stage.sv
// tb_dlx_decode_stage: directed and randomized checks of the DLX decode stage against a decode model
module tb_dlx_decode_stage;
    localparam int MUL_LAT = 4;
    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_LW   = 32'h8C240008;
    localparam logic [31:0] I_ADD2 = 32'h00822820;
    localparam logic [31:0] I_MULT = 32'h0022300E;
    localparam logic [31:0] I_ADDI = 32'h2027FFF0;
    localparam logic [31:0] I_SW   = 32'hAC220004;

    typedef struct packed {
        logic rw, rd, ext, src;
        logic [4:0] op;
        logic br, mw, m2r;
        logic [4:0] s1, s2, d;
        logic [15:0] imm;
    } rec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
    logic [31:0] instr = '0;
    logic RegWr, RegDst, ExtOp, ALUSrc, Branch, MemWr, MemToReg;
    logic [4:0] ALUOp, rs1_o, rs2_o, dst_o;
    logic [15:0] imm_o;
    logic b_in_valid = 1'b0, b_out_ready = 1'b0, b_in_ready, b_out_valid;
    logic [31:0] b_instr = '0;
    logic b_RegWr, b_RegDst, b_ExtOp, b_ALUSrc, b_Branch, b_MemWr, b_MemToReg;
    logic [4:0] b_ALUOp, b_rs1_o, b_rs2_o, b_dst_o;
    logic [15:0] b_imm_o;
    rec_t a_rec, b_rec;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dlx_decode_stage #(.ALUOP_W(5), .MUL_LAT(MUL_LAT), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .RegWr(RegWr), .RegDst(RegDst), .ExtOp(ExtOp),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Branch(Branch), .MemWr(MemWr), .MemToReg(MemToReg),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .dst_o(dst_o), .imm_o(imm_o));

    dlx_decode_stage #(.ALUOP_W(5), .MUL_LAT(1), .HAZARD_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .instr(b_instr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .RegWr(b_RegWr), .RegDst(b_RegDst), .ExtOp(b_ExtOp),
        .ALUSrc(b_ALUSrc), .ALUOp(b_ALUOp), .Branch(b_Branch), .MemWr(b_MemWr), .MemToReg(b_MemToReg),
        .rs1_o(b_rs1_o), .rs2_o(b_rs2_o), .dst_o(b_dst_o), .imm_o(b_imm_o));

    assign a_rec = {RegWr, RegDst, ExtOp, ALUSrc, ALUOp, Branch, MemWr, MemToReg, rs1_o, rs2_o, dst_o, imm_o};
    assign b_rec = {b_RegWr, b_RegDst, b_ExtOp, b_ALUSrc, b_ALUOp, b_Branch, b_MemWr, b_MemToReg, b_rs1_o, b_rs2_o, b_dst_o, b_imm_o};

    function automatic rec_t model(input logic [31:0] i);
        rec_t r;
        logic [5:0] op;
        logic [4:0] d;
        r = '0;
        op = i[31:26];
        d = 5'd0;
        r.s1 = i[25:21];
        r.s2 = i[20:16];
        r.imm = i[15:0];
        if (op == 6'h00) begin r.rw = 1; r.rd = 1; r.op = i[4:0]; d = i[15:11]; end
        else if (op == 6'h08 || op == 6'h23) begin r.rw = 1; r.ext = 1; r.src = 1; r.m2r = op == 6'h23; d = i[20:16]; end
        else if (op == 6'h2B) begin r.mw = 1; r.ext = 1; r.src = 1; end
        else if (op == 6'h04 || op == 6'h05) begin r.br = 1; r.ext = 1; r.op = 5'd2; end
        if (d == 5'd0) r.rw = 0;
        r.d = r.rw ? d : 5'd0;
        return r;
    endfunction

    function automatic logic hz(input rec_t p, input logic [31:0] i);
        return p.m2r && p.d != 5'd0 &&
               (p.d == i[25:21] || ((i[31:26] == 6'h00 || i[31:26] == 6'h2B) && p.d == i[20:16]));
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h15, 6'h3F};
        logic [5:0] fns [4] = '{6'h20, 6'h22, 6'h0E, 6'h2A};
        logic [5:0] op;
        op = ops[$urandom_range(0, 7)];
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom), op == 6'h00 ? fns[$urandom_range(0, 3)] : 6'($urandom)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 1; instr = I_ADD; out_ready = 1; b_in_valid = 0; b_out_ready = 1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        step(); step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || a_rec !== rec_t'(0)) begin errors++; $display("FAIL reset_outputs got v=%b %h want v=0 0", out_valid, a_rec); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid got %b want 0", b_out_valid); end
        step();
        rst_n = 1; in_valid = 0;
    endtask

    task automatic test_add();
        in_valid = 1; instr = I_ADD; out_ready = 1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b want 1", in_ready); end
        step();
        in_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || a_rec !== model(I_ADD)) begin errors++; $display("FAIL add_decode got v=%b %h want v=1 %h", out_valid, a_rec, model(I_ADD)); end
        checks++; if (dst_o !== 5'd3 || ALUOp !== 5'd0 || RegDst !== 1'b1) begin errors++; $display("FAIL add_fields got dst=%0d aluop=%h regdst=%b want 3 00 1", dst_o, ALUOp, RegDst); end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", out_valid); end
    endtask

    task automatic test_load_use();
        int n = 0;
        in_valid = 1; instr = I_LW; out_ready = 1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_lw_accept got %b want 1", in_ready); end
        step();
        instr = I_ADD2;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || a_rec !== model(I_LW)) begin errors++; $display("FAIL lu_lw_decode got %h want %h", a_rec, model(I_LW)); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_hazard_ready got %b want 0", in_ready); end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || a_rec !== rec_t'(0)) begin errors++; $display("FAIL lu_bubble got v=%b %h want v=1 0", out_valid, a_rec); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_bubble_ready got %b want 0", in_ready); end
        step();
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 8) begin step(); @(negedge clk); n++; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_resume got in_ready=%b want 1 within 8", in_ready); end
        step();
        in_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || a_rec !== model(I_ADD2)) begin errors++; $display("FAIL lu_add_follows got v=%b %h want v=1 %h", out_valid, a_rec, model(I_ADD2)); end
        step();
    endtask

    task automatic test_no_hazard();
        b_in_valid = 1; b_instr = I_LW; b_out_ready = 1;
        @(negedge clk);
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL nh_lw_accept got %b want 1", b_in_ready); end
        step();
        b_instr = I_ADD2;
        @(negedge clk);
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL nh_add_ready got %b want 1", b_in_ready); end
        checks++; if (b_rec !== model(I_LW)) begin errors++; $display("FAIL nh_lw_decode got %h want %h", b_rec, model(I_LW)); end
        step();
        b_instr = I_MULT;
        @(negedge clk);
        checks++; if (b_out_valid !== 1'b1 || b_rec !== model(I_ADD2)) begin errors++; $display("FAIL nh_add_next got v=%b %h want v=1 %h", b_out_valid, b_rec, model(I_ADD2)); end
        step();
        b_instr = I_ADDI;
        @(negedge clk);
        checks++; if (b_in_ready !== 1'b1 || b_rec !== model(I_MULT)) begin errors++; $display("FAIL nh_mult_nohold got rdy=%b %h want rdy=1 %h", b_in_ready, b_rec, model(I_MULT)); end
        step();
        b_in_valid = 0;
    endtask

    task automatic test_mult();
        in_valid = 1; instr = I_MULT; out_ready = 1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mult_accept got %b want 1", in_ready); end
        step();
        instr = I_ADDI;
        for (int k = 0; k < MUL_LAT - 1; k++) begin
            @(negedge clk);
            if (k == 0) begin checks++; if (a_rec !== model(I_MULT)) begin errors++; $display("FAIL mult_decode got %h want %h", a_rec, model(I_MULT)); end end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mult_hold_%0d got %b want 0", k, in_ready); end
            step();
        end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mult_release got %b want 1", in_ready); end
        step();
        in_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || a_rec !== model(I_ADDI)) begin errors++; $display("FAIL mult_next got v=%b %h want v=1 %h", out_valid, a_rec, model(I_ADDI)); end
        step();
    endtask

    task automatic test_stall();
        in_valid = 1; instr = I_SW; out_ready = 1;
        @(negedge clk);
        step();
        instr = I_ADDI; out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || a_rec !== model(I_SW)) begin errors++; $display("FAIL stall_hold_%0d got v=%b %h want v=1 %h", k, out_valid, a_rec, model(I_SW)); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d got %b want 0", k, in_ready); end
            step();
        end
        out_ready = 1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || a_rec !== model(I_SW)) begin errors++; $display("FAIL stall_release got rdy=%b %h want rdy=1 %h", in_ready, a_rec, model(I_SW)); end
        step();
        in_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || a_rec !== model(I_ADDI)) begin errors++; $display("FAIL stall_next got v=%b %h want v=1 %h", out_valid, a_rec, model(I_ADDI)); end
        step();
    endtask

    task automatic test_reset_mulhold();
        in_valid = 1; instr = I_MULT; out_ready = 1;
        @(negedge clk);
        step();
        in_valid = 0;
        step();
        rst_n = 0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmh_reset_ready got %b want 0", in_ready); end
        step();
        rst_n = 1; in_valid = 1; instr = I_ADDI;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || a_rec !== rec_t'(0)) begin errors++; $display("FAIL rmh_outputs got v=%b %h want v=0 0", out_valid, a_rec); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmh_ready got %b want 1", in_ready); end
        step();
        in_valid = 0;
        step(); step();
    endtask

    task automatic test_random();
        rec_t q[$];
        rec_t cur, prev, lastreal, pld;
        logic prevstall = 0, pend = 0, took = 0;
        int hold = 0, acc = 0;
        lastreal = '0; prev = '0; pld = '0;
        for (int c = 0; c < 2030; c++) begin
            if (c < 2000) begin
                if (!in_valid || took) begin in_valid = $urandom_range(0, 3) != 0; instr = rnd_instr(); end
                out_ready = $urandom_range(0, 3) != 0;
            end else begin
                in_valid = 0; out_ready = 1;
            end
            @(negedge clk);
            cur = '0;
            if (q.size() > 0) cur = q[0];
            if (prevstall) begin checks++; if (out_valid !== 1'b1 || a_rec !== prev) begin errors++; $display("FAIL rnd_stable c=%0d got v=%b %h want v=1 %h", c, out_valid, a_rec, prev); end end
            if (out_valid && !out_ready) begin checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rnd_backpressure c=%0d got in_ready=%b want 0", c, in_ready); end end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    if (a_rec !== rec_t'(0)) begin errors++; $display("FAIL rnd_bubble c=%0d got %h want 0", c, a_rec); end
                    pend = 1; pld = lastreal;
                end else begin
                    if (a_rec !== q[0]) begin errors++; $display("FAIL rnd_decode c=%0d got %h want %h", c, a_rec, q[0]); end
                    lastreal = q.pop_front();
                end
            end
            took = in_valid && in_ready;
            if (took) begin
                acc++;
                checks++; if (hold != 0) begin errors++; $display("FAIL rnd_mulhold c=%0d accepted with %0d hold cycles left want 0", c, hold); end
                checks++; if (hz(cur, instr)) begin errors++; $display("FAIL rnd_hazard c=%0d accepted %h behind load %h want stall", c, instr, cur); end
                if (pend) begin checks++; if (!hz(pld, instr)) begin errors++; $display("FAIL rnd_bubble_cause c=%0d instr %h after load %h got no dependency want dependency", c, instr, pld); end end
                pend = 0;
                q.push_back(model(instr));
                if (instr[31:26] == 6'h00 && instr[5:0] == 6'h0E) hold = MUL_LAT - 1;
            end else if (hold > 0 && out_ready) hold--;
            prevstall = out_valid && !out_ready;
            prev = a_rec;
            step();
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending want 0", q.size()); end
        checks++; if (acc < 200) begin errors++; $display("FAIL rnd_throughput got %0d accepts want >=200", acc); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_no_hazard();
        test_mult();
        test_stall();
        test_reset_mulhold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
